// File: rtl/umi_pkg.sv
// Shared UMI definitions: command opcodes, arbiter sizing limits and state encoding.
// Imported by umi_arbiter (build option UMI_ARBITER_OUTREG_EN) and umi_arbiter_rr.
package umi_pkg;

    localparam int UMI_MAX_N = 16;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_REQ_RDMA   = 5'h07;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

    typedef logic arb_state_t;

    localparam arb_state_t ARB_IDLE = 1'b0;
    localparam arb_state_t ARB_HOLD = 1'b1;

endpackage

// File: rtl/umi_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant of the first request
// strictly after rr_ptr, wrapping modulo N, via a double-width masked encode.
module umi_arbiter_rr
    import umi_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         grant
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] pick;
    logic           found;

    assign dbl = {req, req};

    // Window covers positions rr_ptr+1 .. rr_ptr+N of the doubled vector
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!found && dbl[j] && j > int'(rr_ptr) && j <= int'(rr_ptr) + N) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign grant = pick[N-1:0] | pick[2*N-1:N];

endmodule

// File: rtl/umi_arbiter.sv
// N-to-1 UMI round-robin arbiter with grant locking while the output stalls.
// UMI_ARBITER_OUTREG_EN adds a 2-entry skid buffer on the output (1-cycle latency).
module umi_arbiter
    import umi_pkg::*;
#(
    parameter int N  = 4,
    parameter int UW = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*UW-1:0] umi_in_packet,
    output logic [N-1:0]    umi_in_ready,
    input  logic [N-1:0]    umi_in_mask,
    output logic            umi_out_valid,
    output logic [UW-1:0]   umi_out_packet,
    input  logic            umi_out_ready,
    output logic [N-1:0]    arb_grant
);

    localparam int PW = $clog2(N);

    arb_state_t    state;
    logic          lock;
    logic [N-1:0]  req;
    logic [N-1:0]  live;
    logic [N-1:0]  grant_rr;
    logic [N-1:0]  grant;
    logic [N-1:0]  grant_q;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic          s_valid;
    logic          s_ready;
    logic          s_fire;
    logic [UW-1:0] s_packet;

    assign lock = (state == ARB_HOLD);
    assign req  = umi_in_valid & ~umi_in_mask;
    // A locked requester keeps its slot even if masked after winning
    assign live = lock ? umi_in_valid : req;

    umi_arbiter_rr #(.N(N)) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (grant_rr)
    );

    assign grant        = reset ? '0 : (lock ? grant_q : grant_rr);
    assign s_valid      = |(grant & live);
    assign s_fire       = s_valid & s_ready;
    assign umi_in_ready = grant & {N{s_ready}};
    assign arb_grant    = grant;

    always_comb begin
        s_packet  = '0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                s_packet  = s_packet | umi_in_packet[i*UW +: UW];
                grant_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            rr_ptr  <= PW'(N - 1);
        end else begin
            if (s_fire)
                rr_ptr <= grant_idx;
            unique case (state)
                ARB_IDLE: begin
                    if (s_valid && !s_ready) begin
                        state   <= ARB_HOLD;
                        grant_q <= grant;
                    end
                end
                ARB_HOLD: begin
                    if (!s_valid || s_ready) begin
                        state   <= ARB_IDLE;
                        grant_q <= '0;
                    end
                end
            endcase
        end
    end

`ifdef UMI_ARBITER_OUTREG_EN
    logic          sk_v0;
    logic          sk_v1;
    logic [UW-1:0] sk_q0;
    logic [UW-1:0] sk_q1;
    logic          sk_pop;

    assign s_ready        = ~sk_v1;
    assign sk_pop         = sk_v0 & umi_out_ready;
    assign umi_out_valid  = sk_v0;
    assign umi_out_packet = sk_q0;

    // Entry 0 is the head; a push while full is impossible since ready is ~sk_v1
    always_ff @(posedge clk) begin
        if (reset) begin
            sk_v0 <= 1'b0;
            sk_v1 <= 1'b0;
        end else if (sk_pop && s_fire) begin
            sk_q0 <= s_packet;
        end else if (sk_pop) begin
            sk_q0 <= sk_q1;
            sk_v0 <= sk_v1;
            sk_v1 <= 1'b0;
        end else if (s_fire) begin
            if (!sk_v0) begin
                sk_q0 <= s_packet;
                sk_v0 <= 1'b1;
            end else begin
                sk_q1 <= s_packet;
                sk_v1 <= 1'b1;
            end
        end
    end
`else
    assign s_ready        = umi_out_ready;
    assign umi_out_valid  = s_valid;
    assign umi_out_packet = s_packet;
`endif

endmodule
